// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states, opcodes,
// and the select/control encodings seen by the datapath and sign extender.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [2:0] F3_BEQ    = 3'b000;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_RDATA  = 2'b01,
        RES_ALURES = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_t;

    function automatic imm_src_t imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:     return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the FSM's alu_op and the instruction
// funct fields.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                // funct7b5 only selects sub for register-register ops; addi ignores it
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// Main control FSM of the multicycle RISC-V core: sequences fetch through
// writeback, drives datapath selects/enables and counts retired instructions.
module riscv_multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           alu_control,
    output logic [1:0]           imm_src,
    output logic                 reg_write,
    output logic                 illegal_instr,
    output logic [INSTRET_W-1:0] instret
);

    state_t  state, state_next;
    alu_op_t alu_op;
    logic    pc_update, branch, ir_write_i, mem_write_i, reg_write_i, retire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        instret <= '0;
        else if (retire) instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:   if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECR;
                    OP_ITYPE:     state_next = S_EXECI;
                    OP_BRANCH:    state_next = (funct3 == F3_BEQ) ? S_BEQ : S_ILLEGAL;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECR,
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_ILLEGAL:  state_next = S_ILLEGAL;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        adr_src       = 1'b0;
        mem_write_i   = 1'b0;
        ir_write_i    = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        reg_write_i   = 1'b0;
        retire        = 1'b0;
        illegal_instr = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                ir_write_i = mem_ready;
                pc_update  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = RES_RDATA;
                reg_write_i = 1'b1;
                retire      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_i = 1'b1;
                retire      = mem_ready;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_i = 1'b1;
                retire      = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                retire    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            S_ILLEGAL: illegal_instr = 1'b1;
            default: ;
        endcase
    end

    // Write enables are masked by the live reset level so nothing commits while held
    assign pc_write  = rst & (pc_update | (branch & zero));
    assign ir_write  = rst & ir_write_i;
    assign mem_write = rst & mem_write_i;
    assign reg_write = rst & reg_write_i;
    assign imm_src   = imm_sel(op);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Self-checking bench: directed table, per-instruction step plans with random
// stalls, illegal-opcode halt and asynchronous reset corner cases.
module tb_riscv_multicycle_controller;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5, zero, mem_ready;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
    logic [31:0] instret;
    logic [16:0] dut_vec;

    riscv_multicycle_controller #(.INSTRET_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .imm_src(imm_src), .reg_write(reg_write), .illegal_instr(illegal_instr),
        .instret(instret)
    );

    always #5 clk = ~clk;

    assign dut_vec = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                      alu_src_b, alu_control, imm_src, reg_write, illegal_instr};

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned model_instret = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One step of an instruction as described architecturally; wait_ready marks
    // a step that repeats while memory is not ready.
    typedef struct {
        bit       wait_ready;
        bit       pcw, adr, memw, irw, regw, branch;
        bit [1:0] res, a, b;
        bit [2:0] alu;
    } step_t;

    step_t plan[$];

    function automatic step_t mk(bit w, bit pcw, bit adr, bit memw, bit irw, bit [1:0] res,
                                 bit [1:0] a, bit [1:0] b, bit [2:0] alu, bit regw, bit br);
        step_t s;
        s.wait_ready = w; s.pcw = pcw; s.adr = adr; s.memw = memw; s.irw = irw;
        s.res = res; s.a = a; s.b = b; s.alu = alu; s.regw = regw; s.branch = br;
        return s;
    endfunction

    function automatic logic [2:0] alu_ref(logic [6:0] o, logic [2:0] f3, logic f7);
        case (f3)
            3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] imm_ref(logic [6:0] o);
        if (o == SW)  return 2'b01;
        if (o == BEQ) return 2'b10;
        if (o == JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic void build_plan(logic [6:0] o, logic [2:0] f3, logic f7);
        plan.delete();
        plan.push_back(mk(1, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0)); // fetch
        plan.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0)); // decode
        case (o)
            LW: begin
                plan.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0));
                plan.push_back(mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
                plan.push_back(mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0));
            end
            SW: begin
                plan.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0));
                plan.push_back(mk(1, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
            end
            RT, IT: begin
                plan.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, (o == IT) ? 2'b01 : 2'b00,
                                  alu_ref(o, f3, f7), 0, 0));
                plan.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
            end
            BEQ: plan.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 1));
            default: begin // jal: link write follows the PC update
                plan.push_back(mk(0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0));
                plan.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
            end
        endcase
    endfunction

    // Entered and left just after a rising edge with the DUT expected in fetch.
    // stalls < 0: random mem_ready; otherwise that many not-ready cycles in each
    // memory wait step after fetch.
    task automatic run_plan(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input int stalls);
        int    idx = 0, guard = 0, waited = 0;
        bit    stalled;
        step_t s;
        op = o; funct3 = f3; funct7b5 = f7;
        build_plan(o, f3, f7);
        while (idx < plan.size() && guard < 100) begin
            s = plan[idx];
            guard++;
            if (stalls < 0) mem_ready = ($urandom_range(0, 99) < 70) || (waited >= 5);
            else            mem_ready = !(s.wait_ready && idx > 0 && waited < stalls);
            zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            stalled = s.wait_ready && !mem_ready;
            check($sformatf("ctl op=%b f3=%b step%0d", o, f3, idx), {15'd0, dut_vec},
                  {15'd0, (stalled ? 1'b0 : (s.pcw | (s.branch & zero))), s.adr, s.memw,
                   (stalled ? 1'b0 : s.irw), s.res, s.a, s.b, s.alu, imm_ref(o), s.regw, 1'b0});
            @(posedge clk); #1;
            if (stalled) waited++;
            else begin idx++; waited = 0; end
        end
        if (guard >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL plan_timeout op=%b: stuck at step %0d, required %0d steps", o, idx, plan.size());
        end
        model_instret++;
        check("instret", instret, model_instret);
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         cycles;
        logic [2:0] alu3;
        logic [1:0] imm;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int          cyc;
        logic [2:0]  alu3;
        logic [1:0]  imm1;
        int unsigned k;
        logic [6:0]  rop;
        logic [2:0]  rf3;

        tbl[0]  = '{RT, 3'b000, 1'b0, 1'b0, 4, 3'b000, 2'b00};
        tbl[1]  = '{RT, 3'b000, 1'b1, 1'b0, 4, 3'b001, 2'b00};
        tbl[2]  = '{IT, 3'b000, 1'b1, 1'b0, 4, 3'b000, 2'b00};
        tbl[3]  = '{RT, 3'b110, 1'b0, 1'b0, 4, 3'b011, 2'b00};
        tbl[4]  = '{RT, 3'b111, 1'b0, 1'b0, 4, 3'b010, 2'b00};
        tbl[5]  = '{IT, 3'b010, 1'b0, 1'b0, 4, 3'b101, 2'b00};
        tbl[6]  = '{RT, 3'b001, 1'b1, 1'b0, 4, 3'b000, 2'b00};
        tbl[7]  = '{LW, 3'b010, 1'b0, 1'b0, 5, 3'b000, 2'b00};
        tbl[8]  = '{SW, 3'b010, 1'b0, 1'b0, 4, 3'b000, 2'b01};
        tbl[9]  = '{BEQ, 3'b000, 1'b0, 1'b1, 3, 3'b001, 2'b10};
        tbl[10] = '{JAL, 3'b101, 1'b0, 1'b0, 4, 3'b000, 2'b11};

        rst = 1'b0; mem_ready = 1'b1; zero = 1'b1; op = RT; funct3 = 3'b000; funct7b5 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_enables", {28'd0, pc_write, mem_write, ir_write, reg_write}, 32'd0);
        check("reset_instret", instret, 32'd0);
        check("reset_illegal", {31'd0, illegal_instr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // lw with three not-ready cycles in the read; first step is the post-reset fetch
        run_plan(LW, 3'b010, 1'b0, 3);
        run_plan(SW, 3'b010, 1'b0, 2);

        foreach (tbl[i]) begin
            op = tbl[i].op; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7;
            zero = tbl[i].z; mem_ready = 1'b1;
            cyc = 0; alu3 = '0; imm1 = '0;
            do begin
                @(negedge clk);
                cyc++;
                if (cyc == 1) imm1 = imm_src;
                if (cyc == 3) alu3 = alu_control;
                @(posedge clk); #1;
            end while (!ir_write && cyc < 20);
            model_instret++;
            check($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cycles);
            check($sformatf("tbl%0d_alu", i), {29'd0, alu3}, {29'd0, tbl[i].alu3});
            check($sformatf("tbl%0d_imm", i), {30'd0, imm1}, {30'd0, tbl[i].imm});
            check($sformatf("tbl%0d_instret", i), instret, model_instret);
        end

        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 5);
            rf3 = 3'($urandom_range(0, 7));
            case (k)
                0: rop = LW;
                1: rop = SW;
                2: rop = RT;
                3: rop = IT;
                4: begin rop = BEQ; rf3 = 3'b000; end
                default: rop = JAL;
            endcase
            run_plan(rop, rf3, 1'($urandom_range(0, 1)), -1);
        end

        // asynchronous reset while a store is waiting on memory
        op = SW; funct3 = 3'b010; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        check("memwrite_before_rst", {31'd0, mem_write}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("memwrite_during_rst", {31'd0, mem_write}, 32'd0);
        check("instret_async_clear", instret, 32'd0);
        model_instret = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        run_plan(RT, 3'b111, 1'b0, 0);

        op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        check("ill_fetch", {15'd0, dut_vec}, {15'd0, 17'b1_0_0_1_10_00_10_000_00_0_0});
        @(posedge clk); #1;
        @(negedge clk);
        check("ill_decode", {15'd0, dut_vec}, {15'd0, 17'b0_0_0_0_00_01_01_000_00_0_0});
        @(posedge clk); #1;
        for (int c = 0; c < 100; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("ill_halt_c%0d", c), {15'd0, dut_vec},
                  {15'd0, 17'b0_0_0_0_00_00_00_000_00_0_1});
            @(posedge clk); #1;
        end
        check("ill_instret", instret, model_instret);
        rst = 1'b0;
        #1;
        check("ill_cleared", {31'd0, illegal_instr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_instret = 0;
        run_plan(BEQ, 3'b000, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
